// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
// Holds the controller state encoding, the BCD digit type and the digit limits.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t UNITS_MAX = 4'd9;
    localparam bcd_t TENS_MAX  = 4'd5;

    // Wide enough for the largest legal TICK_DIV of 2^24 cycles per step.
    localparam int PRESC_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        bcd_t min_t;
        bcd_t min_u;
        bcd_t sec_t;
        bcd_t sec_u;
    } display_t;

    function automatic logic display_is_one(display_t d);
        return d == 16'h0001;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One wrapping BCD digit (0..MAX) with an increment/decrement request.
// carry/borrow are combinational so a whole chain settles within one cycle.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = UNITS_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] value,
    output logic       carry,
    output logic       borrow
);

    bcd_t value_q;
    bcd_t value_d;

    assign value  = value_q;
    assign carry  = inc && (value_q == MAX);
    assign borrow = dec && !inc && (value_q == 4'd0);

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = 4'd0;
        end else if (inc) begin
            value_d = (value_q == MAX) ? 4'd0 : value_q + 4'd1;
        end else if (dec) begin
            value_d = (value_q == 4'd0) ? MAX : value_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch: IDLE/RUN/PAUSE/DONE control, prescaler and BCD digit chain.
// Counts up with 59:59 rollover (wrap pulse) or down to 00:00 (DONE).
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       dir,
    input  logic       set_sec,
    input  logic       set_min,
    output logic [3:0] sec_u,
    output logic [3:0] sec_t,
    output logic [3:0] min_u,
    output logic [3:0] min_t,
    output logic       running,
    output logic       done,
    output logic       wrap
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    state_e               state_q;
    state_e               state_d;
    logic [PRESC_W-1:0]   presc_q;
    logic [PRESC_W-1:0]   presc_d;
    logic                 wrap_q;
    logic                 wrap_d;

    logic     tick;
    logic     step_up;
    logic     step_dn;
    logic     set_mode;
    logic     is_zero;
    logic     start_ok;
    logic     reaches_zero;
    logic     underflow;
    logic     digit_clr;
    display_t disp;

    logic sec_u_inc, sec_u_dec, sec_u_carry, sec_u_borrow;
    logic sec_t_inc, sec_t_dec, sec_t_carry, sec_t_borrow;
    logic min_u_inc, min_u_dec, min_u_carry, min_u_borrow;
    logic min_t_inc, min_t_dec, min_t_carry, min_t_borrow;

    assign disp     = '{min_t: min_t, min_u: min_u, sec_t: sec_t, sec_u: sec_u};
    assign is_zero  = (disp == '0);
    assign tick     = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign step_up  = tick && !dir;
    assign step_dn  = tick && dir;
    assign set_mode = (state_q == ST_IDLE) || (state_q == ST_PAUSE);
    assign start_ok = start_stop && !(dir && is_zero);

    // A down step from 00:00 (possible after an up-rollover and a dir flip)
    // would borrow past the top digit; it is pinned at 00:00 and ends the run.
    assign underflow    = min_t_borrow;
    assign reaches_zero = step_dn && (display_is_one(disp) || underflow);
    assign digit_clr    = clear || underflow;

    // Setting a field wraps inside that field only, so the sec_t carry feeds
    // min_u solely on a real up step.
    assign sec_u_inc = step_up || (set_mode && set_sec);
    assign sec_u_dec = step_dn;
    assign sec_t_inc = sec_u_carry;
    assign sec_t_dec = sec_u_borrow;
    assign min_u_inc = (step_up && sec_t_carry) || (set_mode && set_min);
    assign min_u_dec = sec_t_borrow;
    assign min_t_inc = min_u_carry;
    assign min_t_dec = min_u_borrow;

    bcd_digit_cnt #(.MAX(UNITS_MAX)) u_sec_u (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (digit_clr),
        .inc    (sec_u_inc),
        .dec    (sec_u_dec),
        .value  (sec_u),
        .carry  (sec_u_carry),
        .borrow (sec_u_borrow)
    );

    bcd_digit_cnt #(.MAX(TENS_MAX)) u_sec_t (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (digit_clr),
        .inc    (sec_t_inc),
        .dec    (sec_t_dec),
        .value  (sec_t),
        .carry  (sec_t_carry),
        .borrow (sec_t_borrow)
    );

    bcd_digit_cnt #(.MAX(UNITS_MAX)) u_min_u (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (digit_clr),
        .inc    (min_u_inc),
        .dec    (min_u_dec),
        .value  (min_u),
        .carry  (min_u_carry),
        .borrow (min_u_borrow)
    );

    bcd_digit_cnt #(.MAX(TENS_MAX)) u_min_t (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (digit_clr),
        .inc    (min_t_inc),
        .dec    (min_t_dec),
        .value  (min_t),
        .carry  (min_t_carry),
        .borrow (min_t_borrow)
    );

    // A step and start_stop in the same cycle: the step lands first, and
    // reaching zero on the way down takes precedence over pausing.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (start_ok) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (reaches_zero) begin
                        state_d = ST_DONE;
                    end else if (start_stop) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (clear || tick) begin
            presc_d = '0;
        end else if (state_q == ST_RUN) begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    assign wrap_d = !clear && step_up && min_t_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            wrap_q  <= wrap_d;
        end
    end

    assign running = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a seconds-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_stopwatch_ctrl;

    localparam int TICK = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    typedef struct {
        int secs;
        int state;
        int presc;
        bit wrap;
    } model_t;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear      = 1'b0;
    logic       dir        = 1'b0;
    logic       set_sec    = 1'b0;
    logic       set_min    = 1'b0;
    logic [3:0] sec_u;
    logic [3:0] sec_t;
    logic [3:0] min_u;
    logic [3:0] min_t;
    logic       running;
    logic       done;
    logic       wrap;

    int     checks   = 0;
    int     errors   = 0;
    bit     check_en = 1'b0;
    model_t m        = '{0, M_IDLE, 0, 1'b0};

    logic r_ss, r_cl, r_ssec, r_smin, r_dir;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICK_DIV(TICK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .clear      (clear),
        .dir        (dir),
        .set_sec    (set_sec),
        .set_min    (set_min),
        .sec_u      (sec_u),
        .sec_t      (sec_t),
        .min_u      (min_u),
        .min_t      (min_t),
        .running    (running),
        .done       (done),
        .wrap       (wrap)
    );

    // Reference behaviour on a plain seconds count (0..3599).
    function automatic model_t modelNext(model_t c);
        model_t n;
        int s;
        int mm;
        n = c;
        n.wrap = 1'b0;
        if (clear) begin
            n.secs  = 0;
            n.state = M_IDLE;
            n.presc = 0;
            return n;
        end
        case (c.state)
            M_IDLE, M_PAUSE: begin
                if (start_stop && !(dir && c.secs == 0)) n.state = M_RUN;
                if (set_sec) begin
                    s = n.secs % 60;
                    n.secs = n.secs - s + (s + 1) % 60;
                end
                if (set_min) begin
                    mm = n.secs / 60;
                    n.secs = n.secs - mm * 60 + ((mm + 1) % 60) * 60;
                end
            end
            M_RUN: begin
                if (c.presc == TICK - 1) begin
                    n.presc = 0;
                    if (!dir) begin
                        n.secs = (c.secs + 1) % 3600;
                        n.wrap = (c.secs == 3599);
                    end else if (c.secs <= 1) begin
                        n.secs  = 0;
                        n.state = M_DONE;
                        return n;
                    end else begin
                        n.secs = c.secs - 1;
                    end
                end else begin
                    n.presc = c.presc + 1;
                end
                if (start_stop) n.state = M_PAUSE;
            end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{0, M_IDLE, 0, 1'b0};
        else        m <= modelNext(m);
    end

    task automatic checkOne(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOne("model.sec_u",   int'(sec_u),   m.secs % 10);
            checkOne("model.sec_t",   int'(sec_t),   (m.secs % 60) / 10);
            checkOne("model.min_u",   int'(min_u),   (m.secs / 60) % 10);
            checkOne("model.min_t",   int'(min_t),   m.secs / 600);
            checkOne("model.running", int'(running), int'(m.state == M_RUN));
            checkOne("model.done",    int'(done),    int'(m.state == M_DONE));
            checkOne("model.wrap",    int'(wrap),    int'(m.wrap));
        end
    end

    task automatic checkOutput(input string name, input int mt, input int mu, input int st,
                               input int su, input int r, input int d, input int w);
        checkOne({name, ".min_t"},   int'(min_t),   mt);
        checkOne({name, ".min_u"},   int'(min_u),   mu);
        checkOne({name, ".sec_t"},   int'(sec_t),   st);
        checkOne({name, ".sec_u"},   int'(sec_u),   su);
        checkOne({name, ".running"}, int'(running), r);
        checkOne({name, ".done"},    int'(done),    d);
        checkOne({name, ".wrap"},    int'(wrap),    w);
    endtask

    // Called just after a rising edge; the inputs are sampled on the next one.
    task automatic applyStimulus(input logic ss, input logic cl, input logic ssec,
                                 input logic smin, input logic d);
        start_stop = ss;
        clear      = cl;
        set_sec    = ssec;
        set_min    = smin;
        dir        = d;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        set_sec    = 1'b0;
        set_min    = 1'b0;
    endtask

    task automatic idle(input int n, input logic d);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, d);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_held", 0, 0, 0, 0, 0, 0, 0);
        rst_n    = 1'b1;
        check_en = 1'b1;

        // Count up: first step TICK cycles after start, 00:10 after 40.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("start_up", 0, 0, 0, 0, 1, 0, 0);
        idle(3, 1'b0);
        checkOutput("before_first_step", 0, 0, 0, 0, 1, 0, 0);
        idle(1, 1'b0);
        checkOutput("first_step", 0, 0, 0, 1, 1, 0, 0);
        idle(36, 1'b0);
        checkOutput("forty_cycles", 0, 0, 1, 0, 1, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("clear_run", 0, 0, 0, 0, 0, 0, 0);

        // 59:59 rollover.
        repeat (59) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("set_min59", 5, 9, 0, 0, 0, 0, 0);
        repeat (59) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("set_sec59", 5, 9, 5, 9, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        checkOutput("pre_wrap", 5, 9, 5, 9, 1, 0, 0);
        idle(1, 1'b0);
        checkOutput("wrap_pulse", 0, 0, 0, 0, 1, 0, 1);
        idle(1, 1'b0);
        checkOutput("wrap_over", 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("set_both", 0, 1, 0, 1, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("zero_guard", 0, 0, 0, 0, 0, 0, 0);

        // Count down to DONE; DONE ignores start_stop and set pulses.
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("set_sec2", 0, 0, 0, 2, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b1);
        checkOutput("down_one", 0, 0, 0, 1, 1, 0, 0);
        idle(4, 1'b1);
        checkOutput("down_done", 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("done_ignores", 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("clear_done", 0, 0, 0, 0, 0, 0, 0);

        // Borrow through every digit: 10:00 -> 09:59.
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b1);
        checkOutput("borrow_chain", 0, 9, 5, 9, 1, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Pause with prescaler at 2 holds it; next step 2 cycles after resume.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("paused", 0, 0, 0, 1, 0, 0, 0);
        idle(20, 1'b0);
        checkOutput("pause_hold", 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("resumed", 0, 0, 0, 1, 1, 0, 0);
        idle(1, 1'b0);
        checkOutput("resume_plus1", 0, 0, 0, 1, 1, 0, 0);
        idle(1, 1'b0);
        checkOutput("resume_plus2", 0, 0, 0, 2, 1, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // start_stop on the step edge: the step lands, then pause.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("step_and_pause", 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // 12:34, set ignored in RUN, clear beats start_stop.
        repeat (12) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (34) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("set_1234", 1, 2, 3, 4, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("set_in_run", 1, 2, 3, 4, 1, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("clear_wins", 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a run.
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(6, 1'b0);
        checkOutput("after_reset", 0, 0, 0, 0, 0, 0, 0);

        // Random mix checked cycle by cycle against the model.
        r_dir = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            r_ss   = ($urandom_range(0, 99) < 6);
            r_cl   = ($urandom_range(0, 299) == 0);
            r_ssec = ($urandom_range(0, 99) < 8);
            r_smin = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 39) == 0) r_dir = ~r_dir;
            applyStimulus(r_ss, r_cl, r_ssec, r_smin, r_dir);
        end

        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000: clock cycles per count step; legal range 2..2^24.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start_stop  input  1  one-cycle pulse; toggles run/pause.
REQ-005 clear  input  1  one-cycle pulse; zeroes all digits and returns to IDLE.
REQ-006 dir  input  1  0 = count up, 1 = count down; sampled on each step.
REQ-007 set_sec, set_min  input  1 each  one-cycle pulses; increment the seconds or minutes field while not counting.
REQ-008 sec_u, sec_t, min_u, min_t  output  4 each  BCD digits, ranges 0-9, 0-5, 0-9, 0-5.
REQ-009 running  output  1  high only in RUN.
REQ-010 done  output  1  high only in DONE.
REQ-011 wrap  output  1  one-cycle pulse on an up-count rollover from 59:59 to 00:00.

Function
REQ-012 The FSM SHALL have four states: IDLE, RUN, PAUSE and DONE.
REQ-013 IDLE->RUN on start_stop, except when dir=1 and all digits are 0; in that case the block SHALL stay in IDLE.
REQ-014 RUN->PAUSE on start_stop; PAUSE->RUN on start_stop, with the same zero-guard as REQ-013.
REQ-015 clear SHALL move any state to IDLE and zero all digits on the next edge; clear SHALL win over start_stop, set_* and a step in the same cycle.
REQ-016 Prescaler: it SHALL count only in RUN, hold its value in PAUSE, and be zeroed by clear and on entering DONE; a step occurs on the edge where prescaler == TICK_DIV-1 in RUN, and the prescaler then returns to 0.
REQ-017 The first step after IDLE->RUN SHALL occur exactly TICK_DIV cycles after the start_stop edge.
REQ-018 Up step: sec_u increments; on 9->0 it carries into sec_t (mod 6), then min_u (mod 10), then min_t (mod 6).
REQ-019 59:59 up-step SHALL give 00:00, assert wrap for that one cycle, and stay in RUN.
REQ-020 Down step SHALL borrow symmetrically: sec_u 0->9 borrows from sec_t, sec_t 0->5 from min_u, min_u 0->9 from min_t.
REQ-021 A down step that produces 00:00 SHALL enter DONE on the same edge, so running=0 and done=1 on the following cycle.
REQ-022 DONE SHALL ignore start_stop and set_*; only clear exits DONE.
REQ-023 start_stop in the same cycle as a step SHALL let the step complete, then apply the transition.
REQ-024 set_sec SHALL advance seconds 00..59, wrapping to 00 with no carry into minutes; set_min SHALL do the same for minutes.
REQ-025 set_* SHALL act only in IDLE and PAUSE; if both pulses arrive in one cycle, both fields SHALL advance.
REQ-026 A dir change SHALL take effect at the next step and never alter digits by itself.
REQ-027 Digits SHALL never hold a non-BCD or out-of-range value in any state.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, all digits 0, prescaler 0, running=0, done=0, wrap=0.
REQ-029 Reset mid-RUN SHALL discard the count; operation SHALL resume only after rst_n deasserts and a new start_stop arrives.

Structure
REQ-030 Package stopwatch_pkg SHALL hold the state enum, the digit limits (9 and 5) and the BCD digit typedef.
REQ-031 Sub-module bcd_digit_cnt SHALL implement one digit: parameter MAX; inputs inc and dec; outputs carry and borrow; four instances.
REQ-032 Carry and borrow chains SHALL be combinational within a cycle, and all digits SHALL update on the same edge.

Verification (TICK_DIV=4)
REQ-033 Reset, dir=0, start_stop -> running=1 next cycle; after 4 cycles sec_u=1; after 40 cycles the display reads 00:10.
REQ-034 set_min x59, set_sec x59, dir=0, start, one step -> 00:00, wrap high for exactly one cycle, running stays 1.
REQ-035 set_sec x2, dir=1, start -> 00:01 after 4 cycles and 00:00 after 8 cycles, with done=1 and running=0 one cycle later; start_stop is then ignored.
REQ-036 Start, pause after 6 cycles (prescaler=2), wait 20 cycles, resume -> the next step occurs 2 cycles after resume.
REQ-037 clear and start_stop in the same cycle during RUN at 12:34 -> IDLE, 00:00, running=0.
REQ-038 Random start/pause/set/dir/clear sequences against a reference model -> digits in range and display matching the model on every cycle.
